// File: rtl/queue_exec_unit.sv
// queue_exec_unit: circular operand queue with push, pop and two-operand ALU pair-op.
module queue_exec_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        opcode,
  input  logic [1:0]        alu_fn,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WR_RES} state_t;
  localparam logic [1:0] OP_PUSH = 2'b00, OP_PAIR = 2'b10, OP_POP = 2'b11;
  state_t state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a, b, res;
  logic [PTR_W-1:0] head, tail;
  logic [1:0] fn;
  logic acc, push_ok, mem_we;
  assign op_ready = rst && state == IDLE;
  assign acc = op_valid && op_ready;
  assign full = count == (PTR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = acc && opcode == OP_PUSH && !full;
  assign mem_we = push_ok || state == WR_RES;
  always_comb
    res = fn == 2'b00 ? a + b :
          fn == 2'b01 ? a - b :
          fn == 2'b10 ? a & b : a ^ b;
  always_ff @(posedge clk)
    if (mem_we) mem[tail] <= state == WR_RES ? res : din;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      err <= 1'b0;
      a <= '0;
      b <= '0;
      fn <= '0;
    end else begin
      dout_valid <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          case (opcode)
            OP_PUSH: if (full) err <= 1'b1;
                     else begin
                       tail <= tail + 1'b1;
                       count <= count + 1'b1;
                     end
            OP_POP: if (empty) err <= 1'b1;
                    else begin
                      dout <= mem[head];
                      dout_valid <= 1'b1;
                      head <= head + 1'b1;
                      count <= count - 1'b1;
                    end
            OP_PAIR: if (count < (PTR_W+1)'(2)) err <= 1'b1;
                     else begin
                       fn <= alu_fn;
                       state <= RD_A;
                     end
            default: ;
          endcase
        end
        RD_A: begin
          a <= mem[head];
          head <= head + 1'b1;
          count <= count - 1'b1;
          state <= RD_B;
        end
        RD_B: begin
          b <= mem[head];
          head <= head + 1'b1;
          count <= count - 1'b1;
          state <= WR_RES;
        end
        default: begin
          tail <= tail + 1'b1;
          count <= count + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_queue_exec_unit.sv
// tb_queue_exec_unit: directed vectors with hand-computed expectations for queue_exec_unit.
module tb_queue_exec_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic op_valid = 1'b0;
  logic op_ready;
  logic [1:0] opcode = 2'b01;
  logic [1:0] alu_fn = 2'b00;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic dout_valid;
  logic [3:0] count;
  logic full, empty, err;
  int n_cmp = 0;
  int n_bad = 0;
  queue_exec_unit #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .alu_fn(alu_fn), .din(din), .dout(dout),
    .dout_valid(dout_valid), .count(count), .full(full), .empty(empty), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue(input logic [1:0] opc, input logic [1:0] fn, input logic [7:0] d);
    op_valid = 1'b1;
    opcode = opc;
    alu_fn = fn;
    din = d;
    tick(1);
    op_valid = 1'b0;
    din = 8'hxx;
  endtask
  task automatic push(input logic [7:0] d);
    issue(2'b00, 2'b00, d);
  endtask
  task automatic pair(input logic [1:0] fn);
    issue(2'b10, fn, 8'h00);
  endtask
  task automatic pop_expect(input string tag, input int exp);
    issue(2'b11, 2'b00, 8'h00);
    check({tag, "_dout"}, dout, exp);
    check({tag, "_dv"}, dout_valid, 1);
  endtask
  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", op_ready, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_err", err, 0);
    check("rst_dout", dout, 0);
    tick(1);
    check("rst_ready_held", op_ready, 0);
    rst = 1'b1;
    tick(1);
    check("ready_after_rst", op_ready, 1);
    // push 5, 3; sub -> 2
    push(8'd5);
    push(8'd3);
    pair(2'b01);
    check("pair_busy", op_ready, 0);
    tick(3);
    check("sub_ready", op_ready, 1);
    check("sub_count", count, 1);
    pop_expect("sub_pop", 2);
    tick(1);
    check("dv_one_cycle", dout_valid, 0);
    check("dout_hold", dout, 2);
    check("sub_empty", empty, 1);
    // wrap-around arithmetic
    push(8'd200);
    push(8'd100);
    pair(2'b00);
    tick(3);
    pop_expect("add_wrap", 44);
    push(8'd1);
    push(8'd2);
    pair(2'b01);
    tick(3);
    pop_expect("sub_wrap", 255);
    // and/xor on the same operands
    push(8'hCC);
    push(8'hAA);
    pair(2'b10);
    tick(3);
    pop_expect("and", 8'h88);
    push(8'hCC);
    push(8'hAA);
    pair(2'b11);
    tick(3);
    pop_expect("xor", 8'h66);
    // rejections on empty / short queue
    issue(2'b11, 2'b00, 8'h00);
    check("pop_empty_err", err, 1);
    check("pop_empty_dv", dout_valid, 0);
    check("pop_empty_dout", dout, 8'h66);
    tick(1);
    check("err_one_cycle", err, 0);
    push(8'd7);
    pair(2'b00);
    check("pair_short_err", err, 1);
    check("pair_short_count", count, 1);
    check("pair_short_ready", op_ready, 1);
    issue(2'b01, 2'b00, 8'h00);
    check("nop_err", err, 0);
    check("nop_count", count, 1);
    pop_expect("pop7", 7);
    // fill, overflow, pair-op while full, drain across the wrap
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("full_flag", full, 1);
    check("full_count", count, 8);
    push(8'd9);
    check("overflow_err", err, 1);
    check("overflow_count", count, 8);
    pair(2'b00);
    tick(3);
    check("full_pair_count", count, 7);
    check("full_pair_notfull", full, 0);
    for (int i = 0; i < 7; i++) pop_expect($sformatf("drain%0d", i), i == 6 ? 3 : i + 3);
    check("drain_empty", empty, 1);
    // op_valid held through a pair-op; din changes each cycle
    push(8'd10);
    push(8'd20);
    op_valid = 1'b1;
    opcode = 2'b10;
    alu_fn = 2'b11;
    tick(1);
    opcode = 2'b00;
    din = 8'd11;
    tick(1);
    check("held_e1_count", count, 1);
    din = 8'd22;
    tick(1);
    check("held_e2_count", count, 0);
    din = 8'd33;
    tick(1);
    check("held_e3_count", count, 1);
    check("held_e3_ready", op_ready, 1);
    din = 8'd44;
    tick(1);
    op_valid = 1'b0;
    check("held_e4_count", count, 2);
    pop_expect("held_res", 30);
    pop_expect("held_push", 44);
    // reset during RD_B
    push(8'd4);
    push(8'd6);
    pair(2'b00);
    tick(1);
    rst = 1'b0;
    #2;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_ready", op_ready, 0);
    rst = 1'b1;
    tick(2);
    check("midrst_ready_after", op_ready, 1);
    check("midrst_err", err, 0);
    check("midrst_dv", dout_valid, 0);
    check("midrst_count_after", count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/queue_exec_unit.md
Name: queue_exec_unit

Overview:
- Execution end of the queue calculator: owns the circular operand storage and the front (read) pointer, and consumes the opcode stream.
- Pushes data at the back, pops from the front, and combines the two front entries with an ALU function, writing the result back to the back.
- Sits between the instruction sequencer (op handshake) and the result sink (dout).

Parameters:
DATA_W, 8, operand/result width in bits
DEPTH, 8, queue entries; power of two; pointer width PTR_W = log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-low reset
op_valid  input  1  sequencer presents an operation
op_ready  output  1  unit can accept an operation
opcode  input  2  00 push, 01 nop, 10 pair-op, 11 pop front
alu_fn  input  2  pair-op function: 00 add, 01 sub, 10 and, 11 xor
din  input  DATA_W  push data
dout  output  DATA_W  popped value
dout_valid  output  1  one-cycle strobe, dout holds a popped value
count  output  PTR_W+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
err  output  1  one-cycle strobe, operation rejected

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; head=tail=0; count=0; dout=0; dout_valid=0; err=0; op_ready=0 while rst asserted. Storage contents are not reset. Reset mid-operation aborts it; no partial write survives.
- Accept: an operation is accepted on a rising edge with op_valid && op_ready. op_ready = (state==IDLE). opcode, alu_fn and din are sampled only at accept.
- FSM states: IDLE, RD_A, RD_B, WR_RES.
- Push (00):
  - Not full: at accept, mem[tail]<=din; tail++; count++. Stay in IDLE; one-cycle throughput.
  - Full: no state change; err=1 the next cycle.
- Nop (01): accepted; no effect; no err.
- Pop (11):
  - Not empty: at accept, dout<=mem[head]; head++; count--. dout_valid=1 for exactly the cycle after accept. dout holds its value until the next pop.
  - Empty: err=1 the next cycle; dout unchanged; dout_valid stays 0.
- Pair-op (10):
  - count<2: rejected; err=1 the next cycle; no state change.
  - Otherwise: IDLE->RD_A at accept, latching alu_fn.
  - RD_A edge: a<=mem[head]; head++; count--; ->RD_B.
  - RD_B edge: b<=mem[head]; head++; count--; ->WR_RES.
  - WR_RES edge: mem[tail]<=f(a,b); tail++; count++; ->IDLE.
  - op_ready low for 3 cycles after accept; the next accept is possible on the 4th edge after accept.
  - Net count change is -1.
  - Pair-op is legal when full because the operand reads free space before the write.
- ALU: a is the older (front) entry.
  - add: a+b mod 2^DATA_W.
  - sub: a-b mod 2^DATA_W (two's complement wrap).
  - and: a&b. xor: a^b.
  - No carry or flags.
- Pointers: head and tail are PTR_W bits and wrap DEPTH-1 -> 0 naturally. count is maintained separately, never wraps, and stays within 0..DEPTH.
- err and dout_valid are registered single-cycle strobes and are never asserted together.
- full and empty are combinational from count.

Test Plan:
- Reset mid pair-op: assert rst during RD_B -> count=0, empty=1, op_ready=1 after release, err=0, dout_valid=0.
- Push 5, 3; pair-op sub -> after 3 cycles count=1; pop -> dout=2, dout_valid high exactly 1 cycle; then empty=1.
- Push 8 values 1..8 -> full=1, count=8. Push 9 -> err strobe, count stays 8. Pair-op add -> count=7, back entry=3. Pop x7 -> dout sequence 3,4,5,6,7,8,3, exercising head and tail wrap.
- DATA_W=8: push 200, 100; pair-op add -> 44. Push 1, 2; pair-op sub -> 255.
- Empty queue: pop -> err=1, dout unchanged. Push 7; pair-op -> err=1, count stays 1. Nop -> no err, count unchanged.
- op_valid held high during a pair-op: no accept while op_ready=0; the queued push is accepted on the 4th edge after the pair-op accept, with din sampled at that edge.
